// File: rtl/wb_master_arbiter_if.sv
// Command/response bus between the round-robin arbiter and the single-transaction
// Wishbone master core it drives.
interface wb_master_arbiter_if #(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32
) ();
  logic          m_start;
  logic [aw-1:0] m_address;
  logic [3:0]    m_selection;
  logic          m_write;
  logic [dw-1:0] m_data_wr;
  logic          m_active;
  logic [dw-1:0] m_data_rd;

  modport master (
    output m_start, m_address, m_selection, m_write, m_data_wr,
    input  m_active, m_data_rd
  );

  modport slave (
    input  m_start, m_address, m_selection, m_write, m_data_wr,
    output m_active, m_data_rd
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master command port among NUM_REQ requesters.
// Optional BUSY watchdog with sticky timeout and HALT state: define WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*aw-1:0] req_adr_i,
  input  logic [NUM_REQ*4-1:0]  req_sel_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [NUM_REQ*dw-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [dw-1:0]         rd_data_o,
  output logic                  timeout_o,
  wb_master_arbiter_if.master   m_bus
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned SW = 4;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_e;
`endif

  state_e              state_q, state_d;
  logic [IW-1:0]       last_q, last_d;
  logic                m_start_q, m_start_d;
  logic [aw-1:0]       adr_q, adr_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                we_q, we_d;
  logic [dw-1:0]       dat_q, dat_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [dw-1:0]       rd_q, rd_d;
  logic                clr_cmd;
  logic                rr_found;
  logic [IW-1:0]       rr_idx;
`ifdef WB_ARB_TIMEOUT_EN
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  // Round-robin pick: first active request searching upward from last+1.
  always_comb begin
    int unsigned cand;
    rr_found = 1'b0;
    rr_idx   = last_q;
    cand     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && req_i[IW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(cand);
      end
    end
  end

  // Next state; the m_* registers double as the captured command.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_start_d = 1'b0;
    adr_d     = adr_q;
    sel_d     = sel_q;
    we_d      = we_q;
    dat_d     = dat_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rd_d      = rd_q;
    clr_cmd   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d   = S_ISSUE;
          last_d    = rr_idx;
          m_start_d = 1'b1;
          adr_d     = req_adr_i[32'(rr_idx)*aw +: aw];
          sel_d     = req_sel_i[32'(rr_idx)*SW +: SW];
          we_d      = req_we_i[rr_idx];
          dat_d     = req_dat_i[32'(rr_idx)*dw +: dw];
          gnt_d     = NUM_REQ'(1) << rr_idx;
        end
      end
      S_ISSUE: begin
        state_d = S_BUSY;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_BUSY: begin
        // err/rty also drop m_active, so any return to master idle is completion
        if (!m_bus.m_active) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (32'(cnt_q) + 32'd1 >= TIMEOUT) begin
          state_d   = S_HALT;
          done_d    = gnt_q;
          timeout_d = 1'b1;
          clr_cmd   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        if (!we_q) rd_d = m_bus.m_data_rd;
        state_d = S_IDLE;
        clr_cmd = 1'b1;
      end
`ifdef WB_ARB_TIMEOUT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
    if (clr_cmd) begin
      adr_d = '0;
      sel_d = '0;
      we_d  = 1'b0;
      dat_d = '0;
      gnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      m_start_q <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rd_q      <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_start_q <= m_start_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt_o             = gnt_q;
  assign done_o            = done_q;
  assign rd_data_o         = rd_q;
  assign m_bus.m_start     = m_start_q;
  assign m_bus.m_address   = adr_q;
  assign m_bus.m_selection = sel_q;
  assign m_bus.m_write     = we_q;
  assign m_bus.m_data_wr   = dat_q;
`ifdef WB_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: transaction-level timing model plus directed scenarios
// and randomized requesters; timeout scenario only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_master_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned TO = 15;

  logic           wb_clk = 1'b0;
  logic           wb_rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*AW-1:0] req_adr = '0;
  logic [NR*4-1:0]  req_sel = '0;
  logic [NR-1:0]    req_we = '0;
  logic [NR*DW-1:0] req_dat = '0;
  logic [NR-1:0]    gnt, done;
  logic [DW-1:0]    rd_data;
  logic             timeout;

  wb_master_arbiter_if #(.dw(DW), .aw(AW)) bus ();

  wb_master_arbiter #(.dw(DW), .aw(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .req_i(req), .req_adr_i(req_adr), .req_sel_i(req_sel), .req_we_i(req_we), .req_dat_i(req_dat),
    .gnt_o(gnt), .done_o(done), .rd_data_o(rd_data), .timeout_o(timeout),
    .m_bus(bus)
  );

  always #5 wb_clk = ~wb_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs read by the model when it captures a transaction.
  int          dir_lat = 0;
  bit          dir_rd_set = 0;
  logic [DW-1:0] dir_rdata = '0;

  // Transaction-level model: a capture at cycle t issues at t+1 and completes
  // (done pulse) at t+3+L for L master wait cycles, or at t+2+TO on watchdog expiry.
  int            cyc = 0;
  bit            mbusy = 0, halted = 0, hang = 0, exp_to = 0;
  int            t_cap = 0, done_c = 0, cur_lat = 1, m_last = NR-1, m_win = 0;
  logic [DW-1:0] cur_rdata = '0, exp_rd = '0;
  logic [AW-1:0] c_adr = '0;
  logic [3:0]    c_sel = '0;
  logic          c_we = 1'b0;
  logic [DW-1:0] c_dat = '0;

  always @(posedge wb_clk) begin : model
    if (wb_rst) begin
      mbusy = 0; halted = 0; hang = 0; exp_to = 0; exp_rd = '0; m_last = NR-1;
    end else if (mbusy) begin
      if (cyc == done_c) begin
        mbusy = 0;
        if (hang) begin halted = 1; exp_to = 1; end
        else if (!c_we) exp_rd = cur_rdata;
      end
    end else if (!halted && req != '0) begin
      for (int i = 1; i <= NR; i++) begin
        int k;
        k = (m_last + i) % NR;
        if (req[k]) begin m_win = k; break; end
      end
      m_last    = m_win;
      c_adr     = req_adr[m_win*AW +: AW];
      c_sel     = req_sel[m_win*4 +: 4];
      c_we      = req_we[m_win];
      c_dat     = req_dat[m_win*DW +: DW];
      cur_lat   = (dir_lat != 0) ? dir_lat : int'($urandom_range(5, 1));
      cur_rdata = dir_rd_set ? dir_rdata : $urandom;
      hang      = (cur_lat < 0);
      t_cap     = cyc;
      done_c    = hang ? (cyc + 2 + int'(TO)) : (cyc + 3 + cur_lat);
      mbusy     = 1;
    end
    cyc++;
  end

  // Master core stand-in: busy for cur_lat cycles after start, or forever when hung.
  int mb_cnt = 0;
  bit mb_hang = 0;
  always @(posedge wb_clk) begin
    if (wb_rst) begin
      mb_cnt <= 0; mb_hang <= 0; bus.m_data_rd <= '0;
    end else if (bus.m_start) begin
      mb_cnt <= (cur_lat < 0) ? 1 : cur_lat;
      mb_hang <= (cur_lat < 0);
      bus.m_data_rd <= $urandom;
    end else if (mb_cnt > 0 && !mb_hang) begin
      mb_cnt <= mb_cnt - 1;
      if (mb_cnt == 1) bus.m_data_rd <= cur_rdata;
    end
  end
  assign bus.m_active = bus.m_start || (mb_cnt != 0);

  always @(negedge wb_clk) begin : cmp
    logic [NR-1:0] eg, ed;
    bit inwin;
    if (chk_en) begin
      inwin = mbusy && !(hang && cyc == done_c);
      eg = inwin ? (NR'(1) << m_win) : '0;
      ed = (mbusy && cyc == done_c) ? (NR'(1) << m_win) : '0;
      chk("gnt_o", 64'(gnt), 64'(eg));
      chk("done_o", 64'(done), 64'(ed));
      chk("m_start", 64'(bus.m_start), 64'(mbusy && cyc == t_cap + 1));
      chk("m_address", 64'(bus.m_address), inwin ? 64'(c_adr) : 64'(0));
      chk("m_selection", 64'(bus.m_selection), inwin ? 64'(c_sel) : 64'(0));
      chk("m_write", 64'(bus.m_write), inwin ? 64'(c_we) : 64'(0));
      chk("m_data_wr", 64'(bus.m_data_wr), inwin ? 64'(c_dat) : 64'(0));
      chk("rd_data_o", 64'(rd_data), 64'(exp_rd));
      chk("timeout_o", 64'(timeout), 64'(exp_to));
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (bus.m_start !== 1'b1 && n < 64) begin tick(); n++; end
    chk({tag, "_start"}, 64'(bus.m_start), 64'(1));
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done == '0 && n < 64) begin tick(); n++; end
    chk({tag, "_done_seen"}, 64'(done != '0), 64'(1));
  endtask

  task automatic do_reset();
    req = '0;
    wb_rst = 1'b1;
    tick(); tick();
    wb_rst = 1'b0;
  endtask

  task automatic run_one(input int k, input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                         input logic [DW-1:0] dat, input int lat, input logic [DW-1:0] rdv, input string tag);
    int n;
    req_adr[k*AW +: AW] = adr;
    req_sel[k*4 +: 4]   = sel;
    req_we[k]           = we;
    req_dat[k*DW +: DW] = dat;
    dir_lat = lat; dir_rdata = rdv; dir_rd_set = 1;
    req[k] = 1'b1;
    wait_start(tag, n);
    chk({tag, "_adr"}, 64'(bus.m_address), 64'(adr));
    chk({tag, "_we"}, 64'(bus.m_write), 64'(we));
    chk({tag, "_sel"}, 64'(bus.m_selection), 64'(sel));
    chk({tag, "_dat"}, 64'(bus.m_data_wr), 64'(dat));
    chk({tag, "_gnt"}, 64'(gnt), 64'(NR'(1) << k));
    wait_done(tag, n);
    chk({tag, "_done"}, 64'(done), 64'(NR'(1) << k));
    chk({tag, "_lat"}, 64'(n), 64'(lat + 2));
    req[k] = 1'b0;
    tick();
  endtask

  initial begin : main
    int n;
    tick();
    chk_en = 1;
    tick();
    wb_rst = 1'b0;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rd", 64'(rd_data), 64'(0));
    chk("rst_start", 64'(bus.m_start), 64'(0));

    // single read, master acks in its second wait cycle
    run_one(0, 1'b0, 32'h100, 4'hF, 32'h0, 2, 32'hDEADBEEF, "rd");
    chk("rd_value", 64'(rd_data), 64'(32'hDEADBEEF));

    // write keeps the previous read data
    run_one(1, 1'b0, 32'h200, 4'hF, 32'h0, 1, 32'h12345678, "rd2");
    chk("rd2_value", 64'(rd_data), 64'(32'h12345678));
    run_one(2, 1'b1, 32'h300, 4'h3, 32'hA5A5A5A5, 3, 32'hFFFF0000, "wr");
    chk("wr_keeps_rd", 64'(rd_data), 64'(32'h12345678));

    // request dropped mid-transaction still completes
    req_we[1] = 1'b0; dir_lat = 4; req[1] = 1'b1;
    wait_start("drop", n);
    tick(); tick();
    req[1] = 1'b0;
    wait_done("drop", n);
    chk("drop_done", 64'(done), 64'(4'b0010));
    tick();

    // round robin from reset with all requesters holding
    do_reset();
    dir_lat = 1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start("rr", n);
      chk($sformatf("rr_order%0d", i), 64'(gnt), 64'(NR'(1) << (i % NR)));
      tick();
    end
    req = '0;
    wait_done("rr_tail", n);
    tick();

    // reset in BUSY, then requester 0 beats 3
    dir_lat = 6; req_we[3] = 1'b0; req[3] = 1'b1;
    wait_start("rstb", n);
    tick(); tick();
    wb_rst = 1'b1;
    tick();
    chk("rstb_gnt", 64'(gnt), 64'(0));
    chk("rstb_done", 64'(done), 64'(0));
    chk("rstb_start", 64'(bus.m_start), 64'(0));
    chk("rstb_adr", 64'(bus.m_address), 64'(0));
    chk("rstb_rd", 64'(rd_data), 64'(0));
    wb_rst = 1'b0;
    dir_lat = 1; req_we[0] = 1'b0;
    req = 4'b1001;
    wait_start("rstb_a", n);
    chk("rstb_win0", 64'(gnt), 64'(4'b0001));
    wait_done("rstb_a", n);
    req[0] = 1'b0;
    wait_start("rstb_b", n);
    chk("rstb_win3", 64'(gnt), 64'(4'b1000));
    wait_done("rstb_b", n);
    req = '0;
    tick();

    // randomized requesters with occasional reset
    dir_lat = 0; dir_rd_set = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      wb_rst = ($urandom_range(599, 0) == 0);
      for (int k = 0; k < NR; k++) begin
        req_adr[k*AW +: AW] = $urandom;
        req_dat[k*DW +: DW] = $urandom;
        req_sel[k*4 +: 4]   = 4'($urandom);
        req_we[k]           = 1'($urandom);
        if (req[k]) begin
          if (done[k]) req[k] = 1'($urandom_range(1, 0));
          else if (gnt[k] && $urandom_range(15, 0) == 0) req[k] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req[k] = 1'b1;
        end
      end
    end
    wb_rst = 1'b0;
    req = '0;
    repeat (20) tick();

`ifdef WB_ARB_TIMEOUT_EN
    // master never finishes: watchdog fires TO cycles into BUSY, then no more grants
    do_reset();
    dir_lat = -1; req_we[2] = 1'b0; req[2] = 1'b1;
    wait_start("to", n);
    wait_done("to", n);
    chk("to_done", 64'(done), 64'(4'b0100));
    chk("to_cycles", 64'(n), 64'(TO + 1));
    tick();
    chk("to_flag", 64'(timeout), 64'(1));
    req = 4'b0101; dir_lat = 1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.m_start) n++;
    end
    chk("to_no_start", 64'(n), 64'(0));
    do_reset();
    run_one(0, 1'b0, 32'h40, 4'hF, 32'h0, 1, 32'h0BADF00D, "to_recover");
    chk("to_cleared", 64'(timeout), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end
endmodule
